// File: rtl/line_fetcher.sv
// Prefetches 128-pixel rows of the 4-bit indexed frame buffer from SRAM into ping-pong line
// buffers and serves the palette index of the current VGA pixel one cycle later.
module line_fetcher #(
    parameter logic [19:0] BUF_BASE = 20'h00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  vgaX,
    input  logic [9:0]  vgaY,
    output logic        sram_req,
    output logic [19:0] sram_addr,
    input  logic        sram_gnt,
    input  logic        sram_rd_valid,
    input  logic [15:0] sram_rdata,
    output logic [3:0]  pixel_idx,
    output logic        pixel_valid,
    output logic        fetch_busy,
    output logic        underrun
);
    localparam int unsigned WORDS_ROW = 32;
    localparam int unsigned WIDX_W    = 5;
    localparam int unsigned ROW_W     = 7;
    localparam int unsigned ADDR_W    = 20;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned PROD_W    = 18;
    localparam int unsigned POS_W     = 10;
    localparam logic [POS_W-1:0]  SCREEN_W  = 10'd640;
    localparam logic [POS_W-1:0]  SCREEN_H  = 10'd480;
    localparam logic [ROW_W-1:0]  LAST_ROW  = 7'd95;
    localparam logic [WIDX_W-1:0] LAST_WORD = 5'(WORDS_ROW - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t             state, state_n;
    logic [ROW_W-1:0]   frow, frow_n;
    logic [WIDX_W-1:0]  widx, widx_n;
    logic               pend_valid, pend_valid_n;
    logic [ROW_W-1:0]   pend_row, pend_row_n;
    logic               underrun_n;
    logic               buf_we;
    logic [ADDR_W-1:0]  addr_n;
    logic [POS_W-1:0]   vga_y_q;

    logic [PROD_W-1:0]  x_prod, y_prod;
    logic [ROW_W-1:0]   col, row;
    logic [POS_W-1:0]   row_x5;
    logic               trig_fire;
    logic [ROW_W-1:0]   trig_row;
    logic               pix_vis;
    logic [DATA_W-1:0]  rd_word;
    logic [3:0]         rd_nibble;

    logic [DATA_W-1:0]  line_mem [2][WORDS_ROW];

    // Screen-to-memory mapping: multiply by 205 and drop 10 bits is an exact /5 over 0..639.
    always_comb begin
        x_prod    = PROD_W'(vgaX) * PROD_W'(205);
        y_prod    = PROD_W'(vgaY) * PROD_W'(205);
        col       = ROW_W'(x_prod >> 10);
        row       = ROW_W'(y_prod >> 10);
        row_x5    = POS_W'(row) * POS_W'(5);
        pix_vis   = (vgaX < SCREEN_W) && (vgaY < SCREEN_H);
        rd_word   = line_mem[row[0]][col[6:2]];
        rd_nibble = 4'(rd_word >> {col[1:0], 2'b00});
    end

    // Fetch trigger on a line change: frame end fetches row 0, first line of a row fetches the next.
    always_comb begin
        trig_fire = 1'b0;
        trig_row  = '0;
        if (vgaY != vga_y_q) begin
            if (vgaY == SCREEN_H) begin
                trig_fire = 1'b1;
            end else if ((vgaY < SCREEN_H) && (row_x5 == vgaY) && (row != LAST_ROW)) begin
                trig_fire = 1'b1;
                trig_row  = row + 7'd1;
            end
        end
    end

    always_comb begin
        state_n      = state;
        frow_n       = frow;
        widx_n       = widx;
        pend_valid_n = pend_valid;
        pend_row_n   = pend_row;
        underrun_n   = underrun;
        buf_we       = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig_fire) begin
                    state_n = S_REQ;
                    frow_n  = trig_row;
                    widx_n  = '0;
                end
            end
            S_REQ: begin
                if (sram_gnt) begin
                    state_n = S_WAIT;
                end
                if (trig_fire) begin
                    underrun_n   = 1'b1;
                    pend_valid_n = 1'b1;
                    pend_row_n   = trig_row;
                end
            end
            S_WAIT: begin
                if (sram_rd_valid) begin
                    buf_we = 1'b1;
                    // A newer request always wins over the row being fetched.
                    if (trig_fire) begin
                        underrun_n   = 1'b1;
                        pend_valid_n = 1'b0;
                        state_n      = S_REQ;
                        frow_n       = trig_row;
                        widx_n       = '0;
                    end else if (pend_valid) begin
                        pend_valid_n = 1'b0;
                        state_n      = S_REQ;
                        frow_n       = pend_row;
                        widx_n       = '0;
                    end else if (widx == LAST_WORD) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_REQ;
                        widx_n  = widx + 5'd1;
                    end
                end else if (trig_fire) begin
                    underrun_n   = 1'b1;
                    pend_valid_n = 1'b1;
                    pend_row_n   = trig_row;
                end
            end
            default: state_n = S_IDLE;
        endcase
        addr_n = (state_n == S_REQ)
               ? BUF_BASE + (ADDR_W'(frow_n) << WIDX_W) + ADDR_W'(widx_n)
               : sram_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            frow        <= '0;
            widx        <= '0;
            pend_valid  <= 1'b0;
            pend_row    <= '0;
            underrun    <= 1'b0;
            sram_req    <= 1'b0;
            sram_addr   <= '0;
            fetch_busy  <= 1'b0;
            pixel_idx   <= '0;
            pixel_valid <= 1'b0;
        end else begin
            state       <= state_n;
            frow        <= frow_n;
            widx        <= widx_n;
            pend_valid  <= pend_valid_n;
            pend_row    <= pend_row_n;
            underrun    <= underrun_n;
            sram_req    <= (state_n == S_REQ);
            sram_addr   <= addr_n;
            fetch_busy  <= (state_n != S_IDLE);
            pixel_idx   <= pix_vis ? rd_nibble : 4'd0;
            pixel_valid <= pix_vis;
        end
        vga_y_q <= vgaY;
    end

    // Line buffers are not reset; a same-cycle read of the written word sees the old value.
    always_ff @(posedge clk) begin
        if (buf_we && !reset) begin
            line_mem[frow[0]][widx] <= sram_rdata;
        end
    end

endmodule
